// File: rtl/nird_pkg.sv
// Shared definitions for the NIRD frame sequencer: FSM encoding, packing width,
// output buffer depth and the border test used by both counters and checks.
package nird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PACK_W     = 8;
  localparam int PACK_CNT_W = $clog2(PACK_W);
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  // True when (col,row) lies within b pixels of any frame edge.
  function automatic logic in_border(input int col, input int row,
                                     input int w, input int h, input int b);
    return (col < b) || (col >= w - b) || (row < b) || (row >= h - b);
  endfunction

endpackage

// File: rtl/nird_word_fifo.sv
// Two-entry word buffer between the bit packer and the bit-plane writer.
// Push and pop in the same cycle leave the count unchanged and keep order.
module nird_word_fifo
  import nird_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [PACK_W-1:0] data_i,
  input  logic              pop_i,
  output logic [PACK_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [PACK_W-1:0] r_mem [FIFO_DEPTH];
  // Depth is two, so a single toggling bit addresses each slot.
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = pop_i & ~w_empty;
  assign w_push  = push_i & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/nird_frame_ctrl.sv
// Frame sequencer: counts raster pixels, fires the NI calculator per pixel,
// masks border results and packs indicator bits into buffered 8-bit words.
module nird_frame_ctrl
  import nird_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int BORDER = 1,
  parameter int WIDTH  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [23:0]      S_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             sum_valid_i,
  output logic             sum_ready_o,
  output logic [23:0]      ni_S_o,
  output logic [WIDTH-1:0] ni_sum_o,
  output logic             ni_done_o,
  input  logic             ni_done_i,
  input  logic             ni_bit_i,
  output logic [7:0]       word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             err_o,
  output state_t           dbg_state_o
);

  // Handshakes: a pixel transfers on a rising edge where sum_valid_i and
  // sum_ready_o are both 1; a word transfers where word_valid_o and
  // word_ready_i are both 1. Neither ready depends on its own valid.

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [PACK_CNT_W-1:0] PACK_LAST = PACK_CNT_W'(PACK_W - 1);

  state_t                r_state;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [23:0]           r_S;
  logic                  r_inflight;
  logic                  r_border_d;
  logic                  r_all_acc;
  logic [PACK_W-1:0]     r_pack;
  logic [PACK_CNT_W-1:0] r_pack_cnt;
  logic                  r_err;
  logic                  r_frame_done;

  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [PACK_W-1:0] w_fifo_data;
  logic              w_fifo_full;
  logic              w_ready;
  logic              w_accept;
  logic              w_border;
  logic              w_last_pix;
  logic              w_pack;
  logic              w_bit;
  logic [PACK_W-1:0] w_pack_next;
  logic              w_word_push;
  logic              w_flush_push;
  logic              w_push;
  logic [PACK_W-1:0] w_push_data;
  logic              w_pop;

  assign w_fifo_full = (w_fifo_cnt == CNT_W'(FIFO_DEPTH));

  // Accept only while the buffer can absorb any word this pixel may complete;
  // once the last pixel is taken, wait for its bit before leaving RUN.
  assign w_ready = (r_state == ST_RUN) & ~r_all_acc &
                   ((w_fifo_cnt == '0) |
                    ((w_fifo_cnt == CNT_W'(1)) &
                     ~(r_inflight & (r_pack_cnt == PACK_LAST))));

  assign w_accept   = sum_valid_i & w_ready;
  assign w_border   = in_border(int'(r_col), int'(r_row), IMG_W, IMG_H, BORDER);
  assign w_last_pix = (r_col == COL_LAST) & (r_row == ROW_LAST);

  assign w_pack = ni_done_i & r_inflight;
  assign w_bit  = ni_bit_i & ~r_border_d;

  always_comb begin
    w_pack_next             = r_pack;
    w_pack_next[r_pack_cnt] = w_bit;
  end

  assign w_word_push  = w_pack & (r_pack_cnt == PACK_LAST);
  assign w_flush_push = (r_state == ST_FLUSH) & (r_pack_cnt != '0) & ~w_fifo_full;
  assign w_push       = w_word_push | w_flush_push;
  // Unwritten high bits of a partial word are already zero.
  assign w_push_data  = w_word_push ? w_pack_next : r_pack;
  assign w_pop        = word_valid_o & word_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_S          <= '0;
      r_inflight   <= 1'b0;
      r_border_d   <= 1'b0;
      r_all_acc    <= 1'b0;
      r_pack       <= '0;
      r_pack_cnt   <= '0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (ni_done_i & ~r_inflight) begin
        r_err <= 1'b1;
      end

      if (w_accept) begin
        r_inflight <= 1'b1;
      end else if (w_pack) begin
        r_inflight <= 1'b0;
      end

      if (w_accept) begin
        r_border_d <= w_border;
        if (w_last_pix) begin
          r_all_acc <= 1'b1;
        end
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      if (w_pack) begin
        if (r_pack_cnt == PACK_LAST) begin
          r_pack     <= '0;
          r_pack_cnt <= '0;
        end else begin
          r_pack     <= w_pack_next;
          r_pack_cnt <= r_pack_cnt + PACK_CNT_W'(1);
        end
      end else if (w_flush_push) begin
        r_pack     <= '0;
        r_pack_cnt <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state   <= ST_RUN;
            r_S       <= S_i;
            r_col     <= '0;
            r_row     <= '0;
            r_all_acc <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_pack & r_all_acc) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((r_pack_cnt == '0) | w_flush_push) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_fifo_cnt == '0) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  nird_word_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .count_o (w_fifo_cnt)
  );

  assign sum_ready_o  = w_ready;
  assign ni_S_o       = r_S;
  assign ni_sum_o     = sum_i;
  assign ni_done_o    = w_accept;
  assign word_o       = w_fifo_data;
  assign word_valid_o = (w_fifo_cnt != '0);
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_nird_frame_ctrl.sv
// Directed bench for nird_frame_ctrl: three frame geometries, a registered
// calculator model, and a word scoreboard fed as pixels are accepted.
module tb_nird_frame_ctrl;
  import nird_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wrdy = 1'b1;
  int   sel = 0;

  logic        start_a [3];
  logic [23:0] s_a     [3];
  logic [9:0]  sum_a   [3];
  logic        sv_a    [3];
  logic        rdy_a   [3];
  logic [23:0] nis_a   [3];
  logic [9:0]  nisum_a [3];
  logic        nido_a  [3];
  logic        nidi_a  [3];
  logic        nibit_a [3];
  logic [7:0]  word_a  [3];
  logic        wv_a    [3];
  logic        busy_a  [3];
  logic        fd_a    [3];
  logic        err_a   [3];
  state_t      st_a    [3];
  logic        inj_a   [3];
  logic        calc_d  [3];
  logic        calc_b  [3];

  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt [3];
  int acc_cnt = 0;
  logic [7:0] m_word;
  int m_cnt;
  int m_pix;

  always #5 clk = ~clk;

  // Geometries: 0 = 4x4 border 1, 1 = 5x3 border 0, 2 = 8x6 border 1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    nird_frame_ctrl #(
      .IMG_W (g == 0 ? 4 : (g == 1 ? 5 : 8)),
      .IMG_H (g == 0 ? 4 : (g == 1 ? 3 : 6)),
      .BORDER(g == 1 ? 0 : 1),
      .WIDTH (10)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_a[g]),
      .S_i         (s_a[g]),
      .sum_i       (sum_a[g]),
      .sum_valid_i (sv_a[g]),
      .sum_ready_o (rdy_a[g]),
      .ni_S_o      (nis_a[g]),
      .ni_sum_o    (nisum_a[g]),
      .ni_done_o   (nido_a[g]),
      .ni_done_i   (nidi_a[g]),
      .ni_bit_i    (nibit_a[g]),
      .word_o      (word_a[g]),
      .word_valid_o(wv_a[g]),
      .word_ready_i(wrdy),
      .busy_o      (busy_a[g]),
      .frame_done_o(fd_a[g]),
      .err_o       (err_a[g]),
      .dbg_state_o (st_a[g])
    );
  end

  // Calculator model: answers one cycle after each strobe; instances 0/1
  // always return 1, instance 2 returns bit 0 of the window sum.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      calc_d[k] <= nido_a[k];
      calc_b[k] <= nisum_a[k][0] | (k != 2);
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      nidi_a[k]  = calc_d[k] | inj_a[k];
      nibit_a[k] = calc_b[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fd_a[k]) fd_cnt[k]++;
    end
    if (rst && wrdy && wv_a[sel]) begin
      if (exp_q.size() == 0) begin
        chk("word_extra", {24'd0, word_a[sel]}, 32'h100);
      end else begin
        exp_w = exp_q.pop_front();
        chk("word", {24'd0, word_a[sel]}, {24'd0, exp_w});
      end
    end
  end

  task automatic model_pixel(input logic [9:0] v, input int w, input int h,
                             input int b, input bit ones);
    int col;
    int row;
    logic bt;
    col = m_pix % w;
    row = m_pix / w;
    bt = (ones | v[0]) & !((col < b) || (col >= w - b) || (row < b) || (row >= h - b));
    m_word[m_cnt] = bt;
    m_cnt++;
    if (m_cnt == 8) begin
      exp_q.push_back(m_word);
      m_word = 8'h00;
      m_cnt = 0;
    end
    m_pix++;
    if (m_pix == w * h && m_cnt != 0) begin
      exp_q.push_back(m_word);
      m_word = 8'h00;
      m_cnt = 0;
    end
  endtask

  task automatic send(input int k, input int n, input int w, input int h, input int b);
    logic [9:0] v;
    int waitc;
    for (int i = 0; i < n; i++) begin
      v = 10'($urandom_range(0, 1023));
      sv_a[k] = 1'b1;
      sum_a[k] = v;
      waitc = 0;
      while (!rdy_a[k] && waitc < 300) begin
        @(negedge clk);
        waitc++;
      end
      if (!rdy_a[k]) begin
        chk("send_timeout", 32'(waitc), 32'd0);
        sv_a[k] = 1'b0;
        return;
      end
      model_pixel(v, w, h, b, k != 2);
      acc_cnt++;
      @(negedge clk);
    end
    sv_a[k] = 1'b0;
  endtask

  task automatic start_frame(input int k, input logic [23:0] s);
    m_word = 8'h00;
    m_cnt = 0;
    m_pix = 0;
    start_a[k] = 1'b1;
    s_a[k] = s;
    @(negedge clk);
    start_a[k] = 1'b0;
    s_a[k] = 24'($urandom);
    chk("start_busy", 32'(busy_a[k]), 32'd1);
    chk("start_state", 32'(st_a[k]), 32'(ST_RUN));
    chk("start_S", 32'(nis_a[k]), 32'(s));
  endtask

  task automatic wait_fd(input int k, input int target);
    int c;
    c = 0;
    while (fd_cnt[k] < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    chk("frame_done_count", 32'(fd_cnt[k]), 32'(target));
    chk("idle_busy", 32'(busy_a[k]), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input int k);
    chk("rst_ready", 32'(rdy_a[k]), 32'd0);
    chk("rst_ni_done", 32'(nido_a[k]), 32'd0);
    chk("rst_wvalid", 32'(wv_a[k]), 32'd0);
    chk("rst_word", 32'(word_a[k]), 32'd0);
    chk("rst_busy", 32'(busy_a[k]), 32'd0);
    chk("rst_fdone", 32'(fd_a[k]), 32'd0);
    chk("rst_err", 32'(err_a[k]), 32'd0);
    chk("rst_S", 32'(nis_a[k]), 32'd0);
    chk("rst_state", 32'(st_a[k]), 32'(ST_IDLE));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      s_a[k] = '0;
      sum_a[k] = '0;
      sv_a[k] = 1'b0;
      inj_a[k] = 1'b0;
      fd_cnt[k] = 0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset(k);
    rst = 1'b1;
    @(negedge clk);

    // 4x4, border 1, all ones; a second start with a new threshold mid-frame.
    sel = 0;
    start_frame(0, 24'h123456);
    send(0, 3, 4, 4, 1);
    start_a[0] = 1'b1;
    s_a[0] = 24'hABCDEF;
    @(negedge clk);
    start_a[0] = 1'b0;
    chk("restart_S_kept", 32'(nis_a[0]), 32'h123456);
    chk("restart_busy", 32'(busy_a[0]), 32'd1);
    send(0, 13, 4, 4, 1);
    wait_fd(0, 1);

    // 5x3, no border: full word then zero-padded partial word.
    sel = 1;
    start_frame(1, 24'h000321);
    send(1, 15, 5, 3, 0);
    wait_fd(1, 1);

    // Backpressure: output stalled for 40 cycles under continuous input.
    sel = 2;
    @(posedge clk);
    #1 wrdy = 1'b0;
    @(negedge clk);
    acc_cnt = 0;
    start_frame(2, 24'h0F0F0F);
    fork
      send(2, 48, 8, 6, 1);
      begin
        repeat (40) @(negedge clk);
        chk("bp_accepted", 32'(acc_cnt), 32'd16);
        chk("bp_ready", 32'(rdy_a[2]), 32'd0);
        chk("bp_valid", 32'(wv_a[2]), 32'd1);
        if (exp_q.size() != 0) chk("bp_hold_word", 32'(word_a[2]), 32'(exp_q[0]));
        @(posedge clk);
        #1 wrdy = 1'b1;
      end
    join
    wait_fd(2, 1);

    // Reset after nine pixels, then a clean frame on the same geometry.
    start_frame(2, 24'h00AAAA);
    send(2, 9, 8, 6, 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset(2);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    start_frame(2, 24'h00BBBB);
    send(2, 48, 8, 6, 1);
    wait_fd(2, 2);

    // Stray calculator result while idle sets a sticky error.
    sel = 0;
    inj_a[0] = 1'b1;
    @(negedge clk);
    inj_a[0] = 1'b0;
    chk("err_set", 32'(err_a[0]), 32'd1);
    repeat (5) @(negedge clk);
    chk("err_held", 32'(err_a[0]), 32'd1);
    chk("err_other", 32'(err_a[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("err_cleared", 32'(err_a[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nird_frame_ctrl.md
# nird_frame_ctrl

Frame-level sequencer for the NIRD noise-indicator datapath. Accepts a raster stream of per-pixel window sums, fires the shared NI calculator once per accepted pixel, masks border pixels, and packs the returned indicator bits into 8-bit words behind a 2-entry output buffer with valid/ready backpressure. Sits between the window-sum stage and the bit-plane writer; owns frame counting, the per-frame threshold `S`, and end-of-frame flush.

## Interface
- `IMG_W`, 640: pixels per line.
- `IMG_H`, 480: lines per frame.
- `BORDER`, 1: window radius; pixels within `BORDER` of any edge emit bit 0.
- `WIDTH`, 10: width of `sum_i`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start_i` in 1: start a frame; honoured only in IDLE.
- `S_i` in 24: frame threshold; latched on accepted `start_i`.
- `sum_i` in WIDTH: window sum, raster order.
- `sum_valid_i` in 1: `sum_i` valid.
- `sum_ready_o` out 1: controller accepts `sum_i` this cycle.
- `ni_S_o` out 24: latched threshold to the calculator.
- `ni_sum_o` out WIDTH: `sum_i` passthrough to the calculator.
- `ni_done_o` out 1: calculator strobe, `sum_valid_i & sum_ready_o` (combinational).
- `ni_done_i` in 1: calculator result strobe.
- `ni_bit_i` in 1: calculator result bit, sampled when `ni_done_i`=1.
- `word_o` out 8: packed bits; bit 0 = earliest pixel.
- `word_valid_o` out 1: buffer non-empty.
- `word_ready_i` in 1: downstream consumes `word_o`.
- `busy_o` out 1: state != IDLE.
- `frame_done_o` out 1: one-cycle pulse at frame completion.
- `err_o` out 1: sticky; `ni_done_i` received with nothing in flight.

## Operation
- States: IDLE -> RUN on `start_i`; RUN -> FLUSH after pixel `IMG_W*IMG_H-1` is accepted and its bit packed; FLUSH -> DONE once `pack_cnt`=0 (zero-padding loaded); DONE -> IDLE when buffer empty, pulsing `frame_done_o` on that transition.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance per accepted pixel; `col` wraps to 0 and increments `row`.
- Border flag = `col<BORDER | col>=IMG_W-BORDER | row<BORDER | row>=IMG_H-BORDER`, computed at acceptance and delayed one cycle alongside the in-flight marker.
- Calculator is fired for every pixel, border or not; packed bit = `ni_bit_i & ~border_d`.
- Packing: 8-bit shift register, `pack_cnt` 0..7; on 8th bit the word is pushed into the 2-entry FIFO and `pack_cnt` returns to 0.
- FLUSH: if `pack_cnt`≠0, push the partial word with the remaining high bits 0 in one cycle.
- `sum_ready_o` = RUN & (fifo_cnt=0 | (fifo_cnt=1 & ~(inflight & pack_cnt=7))).
- Simultaneous push and pop: count unchanged, order preserved.
- `start_i` outside IDLE ignored; `S_i` changes outside IDLE ignored.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, counters/`pack_cnt`/FIFO cleared; `sum_ready_o`=0, `ni_done_o`=0, `word_valid_o`=0, `word_o`=0, `busy_o`=0, `frame_done_o`=0, `err_o`=0, `ni_S_o`=0. Mid-frame reset discards in-flight bit and buffered words.
- `start_i` at edge t -> `busy_o`=1 and `sum_ready_o` may rise at t+1.
- Pixel accepted at edge t -> calculator `ni_done_i` at t+1 -> bit packed at edge t+1 -> if it completes a word, `word_valid_o`=1 after edge t+1 (latency 2).
- Sustained throughput 1 pixel/cycle while `word_ready_i`=1.
- `word_o` stable while `word_valid_o`=1 and `word_ready_i`=0.

## Structure
- Shared package `nird_pkg`: state encoding (IDLE, RUN, FLUSH, DONE), `PACK_W`=8, `FIFO_DEPTH`=2.
- One sub-module: `nird_word_fifo` (2-entry, 8-bit, synchronous active-low reset, push/pop/count).
- NI calculator is instantiated by the parent, not inside this block.

## Test plan
- IMG_W=4, IMG_H=4, BORDER=1, calculator bit always 1, `word_ready_i`=1 -> words 0x60, 0x06; `frame_done_o` once.
- IMG_W=5, IMG_H=3, BORDER=0, all bits 1 -> words 0xFF, 0x7F (flush padding), then `frame_done_o`.
- `word_ready_i`=0 for 40 cycles, continuous valid -> exactly 16 pixels accepted (2 words buffered), `sum_ready_o`=0, no bit lost after release.
- Reset asserted mid-frame at pixel 9 -> all outputs at reset values next cycle; new frame produces correct first word.
- `ni_done_i` pulse in IDLE -> `err_o`=1, held until reset.
- `start_i` during RUN with new `S_i` -> ignored; `ni_S_o` keeps frame value.
